// File: rtl/codificacao_instrucao.sv
// Instruction encoder / instruction-memory programmer.
// Takes one instruction per handshake, builds its RV32I word and writes it to
// consecutive word addresses of instruction memory, starting at address 0.
module codificacao_instrucao #(
    parameter int unsigned NUM_INSTR = 32,
    parameter int unsigned ADDR_W    = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [11:0]       immediate,
    input  logic              fim,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              erro,
    output logic              programado
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    localparam logic [2:0] OP_LW   = 3'd0;
    localparam logic [2:0] OP_SW   = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_XOR  = 3'd3;
    localparam logic [2:0] OP_ADDI = 3'd4;
    localparam logic [2:0] OP_SRL  = 3'd5;
    localparam logic [2:0] OP_BEQ  = 3'd6;
    localparam logic [2:0] OP_ILL  = 3'd7;

    typedef enum logic [2:0] {
        OCIOSO,
        CODIFICA,
        ESCREVE,
        CHEIO,
        FINALIZADO
    } state_e;

    state_e              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [4:0]          rd_q, rd_d;
    logic [4:0]          rs1_q, rs1_d;
    logic [4:0]          rs2_q, rs2_d;
    logic [11:0]         imm_q, imm_d;
    logic                in_ready_q, in_ready_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                full_q, full_d;
    logic                erro_q, erro_d;
    logic                programado_q, programado_d;
    logic [31:0]         enc_c;

    // RV32I word assembly from the captured fields
    always_comb begin
        enc_c = 32'h0;
        case (op_q)
            OP_LW:   enc_c = {imm_q, rs1_q, 3'b010, rd_q, 7'b0000011};
            OP_SW:   enc_c = {imm_q[11:5], rs2_q, rs1_q, 3'b010, imm_q[4:0], 7'b0100011};
            OP_SUB:  enc_c = {7'b0100000, rs2_q, rs1_q, 3'b000, rd_q, 7'b0110011};
            OP_XOR:  enc_c = {7'b0000000, rs2_q, rs1_q, 3'b100, rd_q, 7'b0110011};
            OP_ADDI: enc_c = {imm_q, rs1_q, 3'b000, rd_q, 7'b0010011};
            OP_SRL:  enc_c = {7'b0000000, rs2_q, rs1_q, 3'b101, rd_q, 7'b0110011};
            OP_BEQ:  enc_c = {imm_q[11], imm_q[9:4], rs2_q, rs1_q, 3'b000,
                              imm_q[3:0], imm_q[10], 7'b1100011};
            default: enc_c = 32'h0;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        rd_d         = rd_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        imm_d        = imm_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        count_d      = count_q;
        erro_d       = erro_q;

        case (state_q)
            OCIOSO: begin
                // A valid instruction takes priority over the end request
                if (in_valid) begin
                    op_d    = op;
                    rd_d    = rd;
                    rs1_d   = rs1;
                    rs2_d   = rs2;
                    imm_d   = immediate;
                    state_d = CODIFICA;
                end else if (fim) begin
                    state_d = FINALIZADO;
                end
            end
            CODIFICA: begin
                if (op_q == OP_ILL) begin
                    erro_d  = 1'b1;
                    state_d = OCIOSO;
                end else begin
                    mem_wdata_d = enc_c;
                    mem_addr_d  = count_q[ADDR_W-1:0];
                    state_d     = ESCREVE;
                end
            end
            ESCREVE: begin
                count_d = count_q + CNT_W'(1);
                state_d = (count_d == CNT_W'(NUM_INSTR)) ? CHEIO : OCIOSO;
            end
            CHEIO: begin
                if (fim) begin
                    state_d = FINALIZADO;
                end
            end
            FINALIZADO: begin
                state_d = FINALIZADO;
            end
            default: begin
                state_d = OCIOSO;
            end
        endcase

        // Flag outputs follow the state being entered so they are valid with it
        in_ready_d   = (state_d == OCIOSO);
        mem_we_d     = (state_d == ESCREVE);
        full_d       = full_q | (state_d == CHEIO);
        programado_d = (state_d == FINALIZADO);
    end

    // State and output registers; reset drops any write in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= OCIOSO;
            op_q         <= 3'd0;
            rd_q         <= 5'd0;
            rs1_q        <= 5'd0;
            rs2_q        <= 5'd0;
            imm_q        <= 12'd0;
            in_ready_q   <= 1'b1;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'h0;
            count_q      <= '0;
            full_q       <= 1'b0;
            erro_q       <= 1'b0;
            programado_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            rd_q         <= rd_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            imm_q        <= imm_d;
            in_ready_q   <= in_ready_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            count_q      <= count_d;
            full_q       <= full_d;
            erro_q       <= erro_d;
            programado_q <= programado_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign count      = count_q;
    assign full       = full_q;
    assign erro       = erro_q;
    assign programado = programado_q;

endmodule
